// File: rtl/web_choice_encoder.sv
// web_choice_encoder
// Encode side of the web-shooter select/enable interface. Eight raw choice
// buttons are debounced, the lowest-numbered stable choice is captured and
// presented in the bit-reversed 3-bit select code together with enable. The
// code is held until the downstream checker acknowledges it or a timeout
// expires. After a shot a cooldown runs (except for the reload choice), and
// every button must be released before a new choice is accepted.

module web_choice_encoder #(
   parameter int DEBOUNCE_CYCLES = 4,   // consecutive differing samples to flip a stable bit
   parameter int COOLDOWN_CYCLES = 8,   // idle cycles after an acknowledged shot (choices 0-6)
   parameter int ACK_TIMEOUT     = 16   // enable cycles allowed without ack before abort
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] btn,
   input  logic       ack,
   output logic [2:0] select,
   output logic       enable,
   output logic       multi_press,
   output logic       timeout,
   output logic       busy
);

   // Counter widths: each counter only has to reach (LIMIT-1) before it
   // either fires or clears, so it never needs to hold LIMIT itself.
   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int CD_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
   localparam int TO_W = (ACK_TIMEOUT     > 1) ? $clog2(ACK_TIMEOUT)     : 1;

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

   // Select code of the reload choice (choice 7); it skips the cooldown.
   localparam logic [2:0] RELOAD_SELECT = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE         = 2'd0,
      S_ISSUE        = 2'd1,
      S_COOLDOWN     = 2'd2,
      S_WAIT_RELEASE = 2'd3
   } state_t;

   // ------------------------------------------------------------------
   // Debounce: one independent filter per button. Each bit keeps its own
   // run-length counter of samples that disagree with the stable value.
   // ------------------------------------------------------------------
   logic [7:0] stable_q;

   for (genvar gi = 0; gi < 8; gi++) begin : g_debounce
      logic [DB_W-1:0] cnt_q;
      logic [DB_W-1:0] cnt_d;
      logic            stb_q;
      logic            stb_d;

      // Count consecutive disagreeing samples; flip and clear on the last one.
      always_comb begin
         cnt_d = '0;
         stb_d = stb_q;
         if (btn[gi] != stb_q) begin
            if (cnt_q == DB_LAST) begin
               stb_d = ~stb_q;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      // Debounce state register.
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            cnt_q <= '0;
            stb_q <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            stb_q <= stb_d;
         end
      end

      assign stable_q[gi] = stb_q;
   end

   // ------------------------------------------------------------------
   // Priority encode: the lowest choice number wins. Choice n lives on
   // btn[7-n], so the highest set stable bit is the winner.
   // ------------------------------------------------------------------
   logic [2:0] pick_choice;
   logic [2:0] pick_select;
   logic [3:0] pick_count;
   logic       pick_multi;

   // Find the winning choice and count how many buttons are stable-high.
   always_comb begin
      pick_choice = 3'd0;
      pick_count  = 4'd0;
      // Walk from the highest choice number down so the lowest one is the
      // last assignment and therefore wins.
      for (int n = 7; n >= 0; n--) begin
         if (stable_q[7-n]) begin
            pick_choice = 3'(n);
         end
      end
      for (int i = 0; i < 8; i++) begin
         pick_count = pick_count + {3'b000, stable_q[i]};
      end
      // Downstream decoder expects the choice number bit-reversed.
      pick_select = {pick_choice[0], pick_choice[1], pick_choice[2]};
      pick_multi  = (pick_count > 4'd1);
   end

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   state_t          state_q,       state_d;
   logic [2:0]      select_q,      select_d;
   logic            enable_q,      enable_d;
   logic            multi_q,       multi_d;
   logic            timeout_q,     timeout_d;
   logic [TO_W-1:0] to_cnt_q,      to_cnt_d;
   logic [CD_W-1:0] cd_cnt_q,      cd_cnt_d;

   // Next-state and registered-output logic for the capture/issue sequence.
   always_comb begin
      state_d   = state_q;
      select_d  = select_q;    // select is frozen unless a new capture happens
      enable_d  = enable_q;
      multi_d   = 1'b0;        // pulses default low
      timeout_d = 1'b0;
      to_cnt_d  = to_cnt_q;
      cd_cnt_d  = cd_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            enable_d = 1'b0;
            if (stable_q != 8'h00) begin
               select_d = pick_select;
               enable_d = 1'b1;
               multi_d  = pick_multi;
               to_cnt_d = '0;
               state_d  = S_ISSUE;
            end
         end

         S_ISSUE: begin
            // Ack wins over a timeout that would expire on the same edge.
            if (ack) begin
               enable_d = 1'b0;
               if (select_q == RELOAD_SELECT) begin
                  state_d = S_WAIT_RELEASE;
               end else begin
                  cd_cnt_d = '0;
                  state_d  = S_COOLDOWN;
               end
            end else if (to_cnt_q == TO_LAST) begin
               enable_d  = 1'b0;
               timeout_d = 1'b1;
               state_d   = S_WAIT_RELEASE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end

         S_COOLDOWN: begin
            if (cd_cnt_q == CD_LAST) begin
               state_d = S_WAIT_RELEASE;
            end else begin
               cd_cnt_d = cd_cnt_q + 1'b1;
            end
         end

         S_WAIT_RELEASE: begin
            // Presses are never queued: everything must be released first.
            if (stable_q == 8'h00) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d  = S_IDLE;
            enable_d = 1'b0;
         end
      endcase
   end

   // Control state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         select_q  <= 3'b000;
         enable_q  <= 1'b0;
         multi_q   <= 1'b0;
         timeout_q <= 1'b0;
         to_cnt_q  <= '0;
         cd_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         select_q  <= select_d;
         enable_q  <= enable_d;
         multi_q   <= multi_d;
         timeout_q <= timeout_d;
         to_cnt_q  <= to_cnt_d;
         cd_cnt_q  <= cd_cnt_d;
      end
   end

   assign select      = select_q;
   assign enable      = enable_q;
   assign multi_press = multi_q;
   assign timeout     = timeout_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/web_choice_encoder.md
Name: web_choice_encoder

Overview:
- Front end of the web-shooter selection path: the encode side of the 3-bit select/enable interface consumed by the web-choice decoder.
- Debounces the eight raw choice buttons and priority-encodes the first stable press into the team's bit-reversed 3-bit select code.
- Presents that code with enable to the downstream resource checker and holds it until acknowledged.
- Enforces a cooldown between web shots and requires all buttons released before re-arming.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive differing samples needed before a button's stable state flips (>=1)
COOLDOWN_CYCLES, 8, idle cycles enforced after an acknowledged shot, choices 0-6 only (>=1)
ACK_TIMEOUT, 16, maximum cycles enable is held without ack before abort (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous, active-low reset
btn  input  8  raw buttons; btn[7]=choice 0 ... btn[0]=choice 7, active high
ack  input  1  downstream accepted current select
select  output  3  encoded choice: select = {n[0], n[1], n[2]} for choice n (0->000, 1->100, 2->010, 3->110, 4->001, 5->101, 6->011, 7->111)
enable  output  1  select valid; held high until ack or timeout
multi_press  output  1  one-cycle pulse: more than one stable button at capture
timeout  output  1  one-cycle pulse: ack not received within ACK_TIMEOUT
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0 at a rising edge): select=000, enable=0, multi_press=0, timeout=0, busy=0, all stable bits=0, all counters=0, state=IDLE. Reset mid-operation aborts immediately; any pending shot is discarded.
- Debounce, per bit i: counter increments while btn[i] != stable[i], clears when equal. stable[i] flips on the DEBOUNCE_CYCLES-th consecutive differing edge and its counter clears. A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Priority: the lowest choice number wins (highest set bit of stable). multi_press pulses on the capture edge when popcount(stable) > 1.
- States:
  - IDLE: on the edge where stable != 0, register select from the priority winner, set enable=1, go to ISSUE. enable rises one cycle after stable changes.
  - ISSUE: enable=1, select frozen. ack=1 at an edge: enable=0 next cycle; choice 7 (reload) goes to WAIT_RELEASE, others go to COOLDOWN. If ACK_TIMEOUT edges pass with enable=1 and ack=0: enable=0, timeout pulses, go to WAIT_RELEASE (no cooldown).
  - COOLDOWN: count COOLDOWN_CYCLES edges, then go to WAIT_RELEASE.
  - WAIT_RELEASE: stay until stable == 0, then go to IDLE. Presses are never queued.
- ack outside ISSUE is ignored. ack on the same edge as the timeout limit counts as accepted, and timeout does not pulse.
- select retains its last value when enable=0. Consumers must qualify select with enable.
- Button changes during ISSUE or COOLDOWN do not alter select. Debounce keeps running in every state.
- Counters saturate or clear; there is no wrap-around. The cooldown counter is loaded fresh on every entry to COOLDOWN.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with btn=8'hFF -> all outputs 0, busy=0. Release with btn=0 -> remains IDLE.
- Single press: btn=8'b00000100 (choice 5) held -> stable after 4 edges, enable=1 with select=101 one cycle later. Ack on 2nd cycle of enable -> enable=0, then 8 cooldown cycles; release -> IDLE.
- Glitch and priority: 3-cycle pulse on btn[7] -> no enable. Then btn=8'b00110000 held -> select=010 (choice 2), multi_press pulses once.
- Reload bypass: btn[0] held, then ack -> busy stays high only until release; no cooldown delay. Re-press after release -> new enable with select=111.
- Timeout: choice 3 pressed, ack held 0 -> after 16 enable cycles enable=0, timeout pulses one cycle, select=110 retained. No re-issue until buttons are released.
- Mid-op reset and simultaneous ack: assert rst_n=0 during COOLDOWN -> IDLE with outputs 0 next cycle. Separately, ack on the 16th enable cycle -> no timeout pulse; COOLDOWN entered.
